// File: rtl/spi_adc_scanner_if.sv
// Bundle of control, SPI pin and result signals for the multi-channel ADC scanner.
// master = the scanner itself, slave = whatever drives control / consumes results.
interface spi_adc_scanner_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 12
);
  localparam int CH_W = $clog2(N_CH);

  logic              i_enable;
  logic              i_cont;
  logic              i_start;
  logic [DATA_W-1:0] i_thresh;
  logic              MISO;
  logic              MOSI;
  logic              SCK;
  logic              CS;
  logic [DATA_W-1:0] o_data;
  logic [CH_W-1:0]   o_ch;
  logic              o_valid;
  logic              o_scan_done;
  logic [N_CH-1:0]   o_above;
  logic              o_busy;

  modport master (
    input  i_enable, i_cont, i_start, i_thresh, MISO,
    output MOSI, SCK, CS, o_data, o_ch, o_valid, o_scan_done, o_above, o_busy
  );

  modport slave (
    output i_enable, i_cont, i_start, i_thresh, MISO,
    input  MOSI, SCK, CS, o_data, o_ch, o_valid, o_scan_done, o_above, o_busy
  );
endinterface

// File: rtl/spi_adc_scanner.sv
// Multi-channel SPI (mode 0) ADC scanner. Generates SCK from the system clock,
// walks channels 0..N_CH-1, emits one tagged result per frame and keeps a
// per-channel "above threshold" flag. All pin outputs come straight from flops.
module spi_adc_scanner #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 50,
  parameter int GAP_HP  = 2
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  spi_adc_scanner_if.master  bus
);
  localparam int CH_W       = $clog2(N_CH);
  localparam int CMD_W      = 2 + CH_W;
  localparam int FRAME_BITS = CMD_W + DATA_W;
  localparam int XFER_HP    = 2 * FRAME_BITS;
  localparam int HP_MAX     = (XFER_HP > GAP_HP) ? XFER_HP : GAP_HP;
  localparam int HP_W       = $clog2(HP_MAX);
  localparam int DIV_W      = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;     // clk count inside a half-period
  logic [HP_W-1:0]         hp_q, hp_d;       // half-period count inside a state
  logic [CH_W-1:0]         ptr_q, ptr_d;     // channel of the current/next frame
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;       // remaining MOSI bits, MSB next
  logic [DATA_W-1:0]       rx_q, rx_d;       // last DATA_W MISO samples
  logic [DATA_W-1:0]       data_q, data_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [N_CH-1:0]         above_q, above_d;

  logic                    hp_end;
  logic [DIV_W-1:0]        div_inc;
  logic [FRAME_BITS-1:0]   cmd_frame;
  logic                    go_idle;

  assign hp_end    = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_inc   = div_q + DIV_W'(1);
  // Command word for the channel about to be converted; data phase sends zeros.
  assign cmd_frame = {2'b11, ptr_q, {DATA_W{1'b0}}};
  assign go_idle   = bus.i_enable && (bus.i_start || bus.i_cont);

  // Frame sequencer: next state, pin levels and result capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    ptr_d   = ptr_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    ch_d    = ch_q;
    above_d = above_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        hp_d  = '0;
        if (go_idle) begin
          state_d = S_SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = cmd_frame[FRAME_BITS-1];
          tx_d    = cmd_frame << 1;
        end
      end
      S_SETUP: begin
        div_d = div_inc;
        if (hp_end) begin
          // First SCK rise: sample MISO at the same edge SCK goes high.
          div_d   = '0;
          hp_d    = '0;
          state_d = S_XFER;
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], bus.MISO};
        end
      end
      S_XFER: begin
        div_d = div_inc;
        if (hp_end) begin
          div_d = '0;
          if (hp_q == HP_W'(XFER_HP - 1)) begin
            // Last half-period is low, so SCK is already idle for HOLD.
            state_d = S_HOLD;
            hp_d    = '0;
          end else begin
            hp_d  = hp_q + HP_W'(1);
            sck_d = ~sck_q;
            if (sck_q) begin
              mosi_d = tx_q[FRAME_BITS-1];
              tx_d   = tx_q << 1;
            end else begin
              rx_d = {rx_q[DATA_W-2:0], bus.MISO};
            end
          end
        end
      end
      S_HOLD: begin
        div_d = div_inc;
        if (hp_end) begin
          div_d          = '0;
          hp_d           = '0;
          state_d        = S_GAP;
          cs_d           = 1'b1;
          valid_d        = 1'b1;
          data_d         = rx_q;
          ch_d           = ptr_q;
          above_d[ptr_q] = (rx_q > bus.i_thresh);
          done_d         = (ptr_q == CH_W'(N_CH - 1));
          ptr_d          = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + CH_W'(1);
        end
      end
      S_GAP: begin
        div_d = div_inc;
        if (hp_end) begin
          div_d = '0;
          if (hp_q == HP_W'(GAP_HP - 1)) begin
            hp_d = '0;
            // Single scan stops once the pointer wraps; enable is only honoured here.
            if (bus.i_enable && ((ptr_q != '0) || bus.i_cont)) begin
              state_d = S_SETUP;
              cs_d    = 1'b0;
              mosi_d  = cmd_frame[FRAME_BITS-1];
              tx_d    = cmd_frame << 1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            hp_d = hp_q + HP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      ptr_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      above_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      ptr_q   <= ptr_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      above_q <= above_d;
    end
  end

  assign bus.CS          = cs_q;
  assign bus.SCK         = sck_q;
  assign bus.MOSI        = mosi_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_data      = data_q;
  assign bus.o_ch        = ch_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_scan_done = done_q;
  assign bus.o_above     = above_q;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: behavioural ADC on the SPI pins, expected results
// queued per scan, and a monitor that checks every o_valid plus frame timing.
module tb_spi_adc_scanner;
  localparam int N_CH    = 4;
  localparam int DATA_W  = 12;
  localparam int CLK_DIV = 4;
  localparam int GAP_HP  = 2;
  localparam int CH_W    = $clog2(N_CH);
  localparam int CMD_W   = 2 + CH_W;
  localparam int FB      = CMD_W + DATA_W;
  localparam int CS_LOW  = (2 * FB + 2) * CLK_DIV;
  localparam int PERIOD  = (2 * FB + 2 + GAP_HP) * CLK_DIV;
  localparam int TCLK    = 10;
  localparam int IDLE_BOUND = (N_CH + 1) * PERIOD + 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso_r = 1'b0;

  spi_adc_scanner_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  spi_adc_scanner #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .GAP_HP(GAP_HP)
  ) dut (
    .clk_100MHz(clk),
    .reset(rst),
    .bus(bus)
  );

  assign bus.MISO = miso_r;

  always #(TCLK / 2) clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_valid = 0;
  logic [DATA_W-1:0] adc_val [N_CH];
  logic [N_CH-1:0]   exp_above = '0;
  time               t_idle = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ADC model plus frame timing checks, driven by CS/SCK edges.
  logic                 prev_cs = 1'b0;
  logic                 prev_sck = 1'b0;
  int                   nrise = 0;
  logic [CMD_W-1:0]     cmd = '0;
  logic [DATA_W-1:0]    cur_val = '0;
  time                  t_fall = 0;
  time                  t_rise = 0;
  bit                   have_fall = 1'b0;

  always @(bus.CS or bus.SCK) begin
    if (prev_cs && !bus.CS) begin
      if (have_fall && t_idle < t_fall)
        chk("frame_period_clks", ($time - t_fall) / TCLK, PERIOD);
      t_fall    = $time;
      have_fall = 1'b1;
      nrise     = 0;
      cmd       = '0;
    end
    if (!prev_cs && bus.CS && !rst && have_fall) begin
      chk("sck_rises_per_frame", nrise, FB);
      chk("cs_low_clks", ($time - t_fall) / TCLK, CS_LOW);
    end
    if (!prev_sck && bus.SCK) begin
      if (nrise > 0) chk("sck_period_clks", ($time - t_rise) / TCLK, 2 * CLK_DIV);
      t_rise = $time;
      if (nrise < CMD_W) cmd = {cmd[CMD_W-2:0], bus.MOSI};
      else chk("mosi_data_phase_zero", bus.MOSI, 0);
      nrise++;
      if (nrise == CMD_W) begin
        chk("cmd_start_single_bits", cmd[CMD_W-1 -: 2], 2'b11);
        if (sb.size() > 0) chk("cmd_channel", cmd[CH_W-1:0], sb[0].ch);
        cur_val = adc_val[cmd[CH_W-1:0]];
      end
    end
    if (prev_sck && !bus.SCK) begin
      if (nrise >= CMD_W && nrise < FB) miso_r = cur_val[DATA_W-1-(nrise-CMD_W)];
      else miso_r = 1'b0;
    end
    prev_cs  = bus.CS;
    prev_sck = bus.SCK;
  end

  // Result monitor: pops the scoreboard on every o_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst) exp_above = '0;
    if (!bus.o_busy) t_idle = $time;
    if (bus.o_scan_done && !bus.o_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL scan_done_alone: got o_scan_done=1 with o_valid=0 at %0t", $time);
    end
    if (bus.o_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got ch %0d data 0x%0h, expected no result at %0t",
                 bus.o_ch, bus.o_data, $time);
      end else begin
        e = sb.pop_front();
        exp_above[e.ch] = (e.data > bus.i_thresh);
        chk("o_data", bus.o_data, e.data);
        chk("o_ch", bus.o_ch, e.ch);
        chk("o_scan_done", bus.o_scan_done, (e.ch == CH_W'(N_CH - 1)));
        chk("o_above", bus.o_above, exp_above);
      end
    end
  end

  task automatic push_frames(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      int c;
      c = (first + k) % N_CH;
      sb.push_back('{ch: CH_W'(c), data: adc_val[c]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (bus.o_busy && i < IDLE_BOUND) begin
      @(negedge clk);
      i++;
    end
    chk(name, bus.o_busy, 0);
  endtask

  initial begin
    int base;
    int cs_low_seen;
    bus.i_enable = 1'b0;
    bus.i_cont   = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_thresh = '0;
    for (int k = 0; k < N_CH; k++) adc_val[k] = DATA_W'(32'h100 * k + 32'h23);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", bus.CS, 1);
    chk("rst_sck", bus.SCK, 0);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_ch", bus.o_ch, 0);
    chk("rst_above", bus.o_above, 0);
    rst = 1'b0;

    // Reset in the middle of a transfer aborts the frame
    bus.i_enable = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && nrise < 5; i++) @(negedge clk);
    chk("abort_reached_xfer", (nrise >= 5), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs", bus.CS, 1);
    chk("abort_sck", bus.SCK, 0);
    chk("abort_mosi", bus.MOSI, 0);
    chk("abort_busy", bus.o_busy, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);
    chk("abort_no_valid", n_valid, 0);

    // Single scan with the default ADC pattern
    base = n_valid;
    push_frames(0, N_CH);
    pulse_start();
    wait_idle("single_scan_idle");
    cs_low_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.CS) cs_low_seen++;
    end
    chk("single_scan_cs_stays_high", cs_low_seen, 0);
    chk("single_scan_valids", n_valid - base, N_CH);
    chk("single_scan_sb_empty", sb.size(), 0);

    // Threshold is strict: equal is not above
    bus.i_thresh = DATA_W'(12'h800);
    adc_val[1] = DATA_W'(12'h800);
    push_frames(0, N_CH);
    pulse_start();
    wait_idle("thresh_eq_idle");
    chk("thresh_eq_above1", bus.o_above[1], 0);
    adc_val[1] = DATA_W'(12'h801);
    push_frames(0, N_CH);
    pulse_start();
    wait_idle("thresh_gt_idle");
    chk("thresh_gt_above1", bus.o_above[1], 1);

    // Continuous mode, enable dropped during ch1, resume at ch2
    for (int k = 0; k < N_CH; k++) adc_val[k] = DATA_W'(32'h100 * k + 32'h23);
    base = n_valid;
    bus.i_enable = 1'b0;
    push_frames(0, N_CH + 2);
    @(negedge clk);
    bus.i_cont   = 1'b1;
    bus.i_enable = 1'b1;
    for (int i = 0; i < 7 * PERIOD && n_valid < base + N_CH + 1; i++) @(negedge clk);
    chk("cont_reached_second_scan", n_valid - base, N_CH + 1);
    for (int i = 0; i < 2 * PERIOD && bus.CS; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    bus.i_enable = 1'b0;
    bus.i_cont   = 1'b0;
    wait_idle("cont_drop_enable_idle");
    chk("cont_valids", n_valid - base, N_CH + 2);
    chk("cont_sb_empty", sb.size(), 0);
    base = n_valid;
    push_frames(2, N_CH - 2);
    bus.i_enable = 1'b1;
    pulse_start();
    wait_idle("resume_idle");
    chk("resume_valids", n_valid - base, N_CH - 2);

    // Start pulses while busy are ignored
    for (int k = 0; k < N_CH; k++) adc_val[k] = DATA_W'($urandom);
    base = n_valid;
    push_frames(0, N_CH);
    pulse_start();
    repeat (5) begin
      repeat ($urandom_range(5, 90)) @(negedge clk);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    wait_idle("busy_start_idle");
    repeat (2 * PERIOD) @(negedge clk);
    chk("busy_start_valids", n_valid - base, N_CH);

    // Randomized scans with random data and thresholds
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_CH; k++) adc_val[k] = DATA_W'($urandom);
      bus.i_thresh = DATA_W'($urandom);
      push_frames(0, N_CH);
      pulse_start();
      wait_idle("random_scan_idle");
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
